uart_rx16: RTL and testbench

UART_RX16 -- requirements
Module: uart_rx16

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx16.sv | 171 +++++++++++++++++
 tb/tb_uart_rx16.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the receiver/transmitter FSM state encoding.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVS       = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx16.sv
// UART receiver with OVS-times oversampling strobe, single holding register,
// framing and overrun flags.
`timescale 1ns/1ps
module uart_rx16
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int OVS       = UART_OVS
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 en16,
  input  logic                 rxd,
  input  logic                 rdrst,
  output logic [DATA_BITS-1:0] rbr,
  output logic                 rdrdy,
  output logic                 ferr,
  output logic                 oerr
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(32'd1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 sync1_r;
  logic                 rxd_s;
  uart_state_e          state_r, state_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [BW-1:0]        bit_r, bit_nxt_s;
  logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                 done_s;
  logic [DATA_BITS-1:0] rbr_r;
  logic                 rdrdy_r;
  logic                 ferr_r;
  logic                 oerr_r;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      sync1_r <= rxd;
      rxd_s   <= sync1_r;
    end
  end

  // FSM, tick counter, bit counter and shift register state
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= BIT_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic; done_s marks the cycle the stop bit is sampled
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt_s = START;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (en16) begin
          if (cnt_r == CNT_HALF) begin
            cnt_nxt_s   = CNT_ZERO;
            bit_nxt_s   = BIT_ZERO;
            state_nxt_s = rxd_s ? IDLE : DATA;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DATA: begin
        if (en16) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = CNT_ZERO;
            shift_nxt_s = {rxd_s, shift_r[DATA_BITS-1:1]};
            if (bit_r == BIT_LAST) begin
              state_nxt_s = STOP;
            end else begin
              bit_nxt_s = bit_r + BIT_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      STOP: begin
        if (en16) begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = CNT_ZERO;
            done_s      = 1'b1;
            state_nxt_s = rxd_s ? IDLE : WAITHI;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      WAITHI: begin
        if (rxd_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAITHI;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Holding register and status flags; an acknowledge coinciding with
  // completion frees the register before the new frame is considered
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rbr_r   <= {DATA_BITS{1'b0}};
      rdrdy_r <= 1'b0;
      ferr_r  <= 1'b0;
      oerr_r  <= 1'b0;
    end else if (done_s) begin
      if (!rdrdy_r || rdrst) begin
        rbr_r   <= shift_r;
        rdrdy_r <= 1'b1;
        ferr_r  <= ~rxd_s;
        oerr_r  <= oerr_r & ~rdrst;
      end else begin
        oerr_r  <= 1'b1;
      end
    end else if (rdrst) begin
      rdrdy_r <= 1'b0;
      oerr_r  <= 1'b0;
    end
  end

  assign rbr   = rbr_r;
  assign rdrdy = rdrdy_r;
  assign ferr  = ferr_r;
  assign oerr  = oerr_r;

endmodule

// File: tb/tb_uart_rx16.sv
// Self-checking bench for uart_rx16: directed scenarios plus randomized frames
// compared against a frame-level model of the holding register and flags.
`timescale 1ns/1ps
module tb_uart_rx16;
  import uart_pkg::*;

  localparam int DIV = 4;  // en16 period in CLK cycles; the receiver only counts strobes

  logic       CLK = 1'b0;
  logic       rst;
  logic       en16 = 1'b0;
  logic       rxd;
  logic       rdrst;
  logic [7:0] rbr;
  logic       rdrdy, ferr, oerr;

  int checks = 0;
  int errors = 0;
  int divc   = 0;

  logic [7:0] m_rbr;
  logic       m_rdrdy, m_ferr, m_oerr;

  uart_rx16 #(.DATA_BITS(8), .OVS(16)) dut (
    .CLK(CLK), .rst(rst), .en16(en16), .rxd(rxd), .rdrst(rdrst),
    .rbr(rbr), .rdrdy(rdrdy), .ferr(ferr), .oerr(oerr)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) begin
    divc <= (divc == DIV - 1) ? 0 : divc + 1;
    en16 <= (divc == DIV - 1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Frame-level model: an acknowledge in the completion cycle is applied first
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic ack);
    if (ack) begin m_rdrdy = 1'b0; m_oerr = 1'b0; end
    if (!m_rdrdy) begin
      m_rbr = d; m_rdrdy = 1'b1; m_ferr = !stop;
    end else begin
      m_oerr = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_rbr = 8'h00; m_rdrdy = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
  endtask

  // Returns at the falling edge just before the n-th following en16 strobe edge
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      while (en16 !== 1'b1) @(negedge CLK);
    end
  endtask

  task automatic pulse_ack();
    @(negedge CLK); rdrst = 1'b1;
    @(negedge CLK); rdrst = 1'b0;
    m_rdrdy = 1'b0; m_oerr = 1'b0;
  endtask

  // Sends one frame; pre/post are rdrdy just before and just after the completion edge
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack,
                            output logic pre, output logic post);
    tick_wait(1);
    rxd = 1'b0;
    tick_wait(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick_wait(16);
    end
    rxd = stop;
    tick_wait(8);
    pre = rdrdy;
    if (ack) rdrst = 1'b1;
    @(negedge CLK);
    rdrst = 1'b0;
    post = rdrdy;
    model_frame(d, stop, ack);
    tick_wait(7);
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rdrst = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    if ({rbr, rdrdy, ferr, oerr} !== 11'h000) begin errors++; $display("FAIL reset_in got %h exp 000", {rbr, rdrdy, ferr, oerr}); end
    checks++;
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    if ({rbr, rdrdy, ferr, oerr} !== 11'h000) begin errors++; $display("FAIL reset_out got %h exp 000", {rbr, rdrdy, ferr, oerr}); end
    checks++;
    if (dut.state_r !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_r, IDLE); end
    checks++;
  endtask

  task automatic test_basic();
    logic pre, post;
    send_frame(8'h55, 1'b1, 1'b0, pre, post);
    if (pre !== 1'b0) begin errors++; $display("FAIL basic_latency_pre got %b exp 0", pre); end
    checks++;
    if (post !== 1'b1) begin errors++; $display("FAIL basic_latency_post got %b exp 1", post); end
    checks++;
    if (rbr !== 8'h55) begin errors++; $display("FAIL basic_rbr got %h exp 55", rbr); end
    checks++;
    if ({rdrdy, ferr, oerr} !== {m_rdrdy, m_ferr, m_oerr}) begin
      errors++; $display("FAIL basic_flags got %b exp %b", {rdrdy, ferr, oerr}, {m_rdrdy, m_ferr, m_oerr});
    end
    checks++;
  endtask

  task automatic test_overrun();
    logic pre, post;
    pulse_ack();
    send_frame(8'hA3, 1'b1, 1'b0, pre, post);
    send_frame(8'h3C, 1'b1, 1'b0, pre, post);
    if (rbr !== m_rbr) begin errors++; $display("FAIL overrun_rbr got %h exp %h", rbr, m_rbr); end
    checks++;
    if ({rdrdy, ferr, oerr} !== 3'b101) begin errors++; $display("FAIL overrun_flags got %b exp 101", {rdrdy, ferr, oerr}); end
    checks++;
    pulse_ack();
    @(negedge CLK);
    if ({rdrdy, oerr} !== {m_rdrdy, m_oerr}) begin errors++; $display("FAIL overrun_ack got %b exp %b", {rdrdy, oerr}, {m_rdrdy, m_oerr}); end
    checks++;
  endtask

  task automatic test_glitch();
    tick_wait(1);
    rxd = 1'b0;
    tick_wait(3);
    rxd = 1'b1;
    tick_wait(16);
    if (dut.state_r !== IDLE) begin errors++; $display("FAIL glitch_state got %0d exp %0d", dut.state_r, IDLE); end
    checks++;
    if (rdrdy !== m_rdrdy) begin errors++; $display("FAIL glitch_rdrdy got %b exp %b", rdrdy, m_rdrdy); end
    checks++;
  endtask

  task automatic test_break();
    logic pre, post;
    send_frame(8'h0F, 1'b0, 1'b0, pre, post);
    tick_wait(16 * 20);
    if (rbr !== 8'h0F) begin errors++; $display("FAIL break_rbr got %h exp 0f", rbr); end
    checks++;
    if ({rdrdy, ferr, oerr} !== 3'b110) begin errors++; $display("FAIL break_flags got %b exp 110", {rdrdy, ferr, oerr}); end
    checks++;
    rxd = 1'b1;
    tick_wait(16);
    pulse_ack();
    send_frame(8'h81, 1'b1, 1'b0, pre, post);
    if (rbr !== 8'h81) begin errors++; $display("FAIL break_next_rbr got %h exp 81", rbr); end
    checks++;
    if ({rdrdy, ferr, oerr} !== {m_rdrdy, m_ferr, m_oerr}) begin
      errors++; $display("FAIL break_next_flags got %b exp %b", {rdrdy, ferr, oerr}, {m_rdrdy, m_ferr, m_oerr});
    end
    checks++;
  endtask

  task automatic test_coincide();
    logic pre, post;
    send_frame(8'h7E, 1'b1, 1'b1, pre, post);
    if (pre !== 1'b1) begin errors++; $display("FAIL coincide_pre got %b exp 1", pre); end
    checks++;
    if (rbr !== 8'h7E) begin errors++; $display("FAIL coincide_rbr got %h exp 7e", rbr); end
    checks++;
    if ({rdrdy, ferr, oerr} !== 3'b100) begin errors++; $display("FAIL coincide_flags got %b exp 100", {rdrdy, ferr, oerr}); end
    checks++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] part;
    logic pre, post;
    part = 8'h5A;
    tick_wait(1);
    rxd = 1'b0;
    tick_wait(16);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      tick_wait(16);
    end
    rxd = part[4];
    tick_wait(8);
    rst = 1'b1; rxd = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    tick_wait(32);
    if ({rbr, rdrdy, ferr, oerr} !== 11'h000) begin errors++; $display("FAIL midrst_clear got %h exp 000", {rbr, rdrdy, ferr, oerr}); end
    checks++;
    send_frame(8'hC9, 1'b1, 1'b0, pre, post);
    if (rbr !== 8'hC9) begin errors++; $display("FAIL midrst_rbr got %h exp c9", rbr); end
    checks++;
    if ({rdrdy, ferr, oerr} !== 3'b100) begin errors++; $display("FAIL midrst_flags got %b exp 100", {rdrdy, ferr, oerr}); end
    checks++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic stop, ack, pre, post;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      ack  = ($urandom_range(3) == 0);
      if ($urandom_range(1) == 1) pulse_ack();
      send_frame(d, stop, ack, pre, post);
      if (rbr !== m_rbr) begin errors++; $display("FAIL rand%0d_rbr got %h exp %h", n, rbr, m_rbr); end
      checks++;
      if ({rdrdy, ferr, oerr} !== {m_rdrdy, m_ferr, m_oerr}) begin
        errors++; $display("FAIL rand%0d_flags got %b exp %b", n, {rdrdy, ferr, oerr}, {m_rdrdy, m_ferr, m_oerr});
      end
      checks++;
      if (!stop) begin
        rxd = 1'b1;
        tick_wait(16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_break();
    test_coincide();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
